// File: rtl/ddr_arbiter_pkg.sv
// ddr_arbiter_pkg
// Shared definitions for the DDRAM burst arbiter: the arbiter state
// encoding, the largest supported requester count, and the helper that
// sizes requester index signals.
// Ports: none (package).

package ddr_arbiter_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    // Width of a requester index; never below one bit so a two-port
    // arbiter still has a real index signal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr_arbiter_if.sv
// ddr_arbiter_if
// Bundles the requester-side burst ports and the upstream DDRAM port of
// the arbiter.
// Ports (signals):
//   req_rd/req_wr/req_addr/req_burstLength/req_mask/req_din : per-port commands
//   req_waitReq/req_valid/req_burstDone                     : per-port status
//   req_dout                                                : shared read data
//   ddr_rd/ddr_wr/ddr_addr/ddr_burstLength/ddr_mask/ddr_din : upstream command
//   ddr_dout/ddr_waitReq/ddr_valid                          : upstream response
// Modports: master = requesters plus the DDRAM side, slave = arbiter.

interface ddr_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]                 req_rd;
    logic [NUM_REQ-1:0]                 req_wr;
    logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr;
    logic [NUM_REQ-1:0][7:0]            req_burstLength;
    logic [NUM_REQ-1:0][DATA_W/8-1:0]   req_mask;
    logic [NUM_REQ-1:0][DATA_W-1:0]     req_din;
    logic [NUM_REQ-1:0]                 req_waitReq;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_burstDone;
    logic [DATA_W-1:0]                  req_dout;

    logic                               ddr_rd;
    logic                               ddr_wr;
    logic [ADDR_W-1:0]                  ddr_addr;
    logic [7:0]                         ddr_burstLength;
    logic [DATA_W/8-1:0]                ddr_mask;
    logic [DATA_W-1:0]                  ddr_din;
    logic [DATA_W-1:0]                  ddr_dout;
    logic                               ddr_waitReq;
    logic                               ddr_valid;

    modport master (
        output req_rd, req_wr, req_addr, req_burstLength, req_mask, req_din,
        output ddr_dout, ddr_waitReq, ddr_valid,
        input  req_waitReq, req_valid, req_burstDone, req_dout,
        input  ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din
    );

    modport slave (
        input  req_rd, req_wr, req_addr, req_burstLength, req_mask, req_din,
        input  ddr_dout, ddr_waitReq, ddr_valid,
        output req_waitReq, req_valid, req_burstDone, req_dout,
        output ddr_rd, ddr_wr, ddr_addr, ddr_burstLength, ddr_mask, ddr_din
    );

endinterface

// File: rtl/ddr_arbiter_rr_priority_encoder.sv
// rr_priority_encoder
// Combinational round-robin encoder: returns the first asserted request
// found when searching upward from ptr, wrapping at NUM_REQ.
// Ports:
//   request : in  NUM_REQ  request vector
//   ptr     : in  IDX_W    index where the search starts
//   grant   : out IDX_W    winning index (0 when nothing requests)
//   any     : out 1        at least one request is asserted

module rr_priority_encoder
    import ddr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // The "any" flag doubles as a found marker so later candidates in the
    // wrapped search order cannot override the first hit.
    always_comb begin
        grant    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && request[cand_idx]) begin
                any   = 1'b1;
                grant = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter
// Shares one DDRAM burst port between NUM_REQ requesters. Each requester
// owns the port for a whole burst; owners are chosen round-robin and read
// data/handshakes are routed back to the current owner.
// Ports:
//   clock   : in  system clock
//   reset_n : in  synchronous active-low reset
//   bus     : ddr_arbiter_if.slave, requester ports and upstream DDRAM port
//             (address/data widths come from the interface parameters)

module ddr_arbiter
    import ddr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    ddr_arbiter_if.slave    bus
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t       state, next_state;
    logic [IDX_W-1:0] ptr, next_ptr;
    logic [IDX_W-1:0] owner, next_owner;
    logic [7:0]       beats, next_beats;

    logic [IDX_W-1:0] grant;
    logic             any;
    logic [IDX_W-1:0] sel;
    logic [7:0]       len_eff;
    logic             cmd_rd;
    logic             cmd_wr;
    logic             wr_beat;

    rr_priority_encoder #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_encoder (
        .request (bus.req_rd | bus.req_wr),
        .ptr     (ptr),
        .grant   (grant),
        .any     (any)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            beats <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            owner <= next_owner;
            beats <= next_beats;
        end
    end

    // Command fields come from the encoder winner while idle and from the
    // burst owner otherwise; only the strobes and handshakes depend on state.
    // All strobes are held inactive while reset_n is low.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_owner = owner;
        next_beats = beats;

        sel     = (state == IDLE) ? grant : owner;
        len_eff = (bus.req_burstLength[grant] == 8'd0) ? 8'd1 : bus.req_burstLength[grant];
        cmd_rd  = bus.req_rd[grant];
        cmd_wr  = bus.req_wr[grant] & ~bus.req_rd[grant];
        wr_beat = bus.req_wr[owner] & ~bus.ddr_waitReq;

        bus.ddr_addr        = bus.req_addr[sel];
        bus.ddr_burstLength = bus.req_burstLength[sel];
        bus.ddr_mask        = bus.req_mask[sel];
        bus.ddr_din         = bus.req_din[sel];
        bus.ddr_rd          = 1'b0;
        bus.ddr_wr          = 1'b0;
        bus.req_waitReq     = '1;
        bus.req_valid       = '0;
        bus.req_burstDone   = '0;
        bus.req_dout        = bus.ddr_dout;

        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (any) begin
                        bus.ddr_rd             = cmd_rd;
                        bus.ddr_wr             = cmd_wr;
                        bus.req_waitReq[grant] = bus.ddr_waitReq;
                        if (!bus.ddr_waitReq) begin
                            next_owner = grant;
                            next_ptr   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
                            if (cmd_rd) begin
                                next_beats = len_eff;
                                next_state = READ;
                            end else begin
                                // The acceptance cycle carries the first write beat.
                                next_beats = len_eff - 8'd1;
                                if (len_eff == 8'd1) begin
                                    bus.req_burstDone[grant] = 1'b1;
                                end else begin
                                    next_state = WRITE;
                                end
                            end
                        end
                    end
                end
                READ: begin
                    bus.req_valid[owner] = bus.ddr_valid;
                    if (bus.ddr_valid) begin
                        next_beats = beats - 8'd1;
                        if (beats == 8'd1) begin
                            bus.req_burstDone[owner] = 1'b1;
                            next_state               = IDLE;
                        end
                    end
                end
                WRITE: begin
                    bus.ddr_wr             = bus.req_wr[owner];
                    bus.req_waitReq[owner] = bus.ddr_waitReq;
                    if (wr_beat) begin
                        next_beats = beats - 8'd1;
                        if (beats == 8'd1) begin
                            bus.req_burstDone[owner] = 1'b1;
                            next_state               = IDLE;
                        end
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr_arbiter.md
# ddr_arbiter

Shares the single DDRAM port between several burst requesters: ROM download writer, frame-buffer writer and tile/sprite ROM reader. Each requester gets one whole burst at a time, granted in round-robin order, with read data and handshakes routed back to the owner. Sits in the `clock` (clk_sys) domain between the requester blocks and the top-level DDRAM_* pins.

## Interface
- NUM_REQ, 3: number of requester ports (2..8).
- ADDR_W, 32: byte address width.
- DATA_W, 64: data width; mask width is DATA_W/8.
- clock  in  1  system clock (DDRAM_CLK domain).
- reset_n  in  1  synchronous, active-low reset, sampled on rising `clock`.
- req_rd  in  NUM_REQ  per-port read strobe.
- req_wr  in  NUM_REQ  per-port write strobe.
- req_addr  in  NUM_REQ×ADDR_W  per-port burst start address.
- req_burstLength  in  NUM_REQ×8  per-port beat count.
- req_mask  in  NUM_REQ×DATA_W/8  per-port byte enables.
- req_din  in  NUM_REQ×DATA_W  per-port write data.
- req_waitReq  out  NUM_REQ  per-port stall.
- req_valid  out  NUM_REQ  per-port read-data strobe.
- req_burstDone  out  NUM_REQ  one-cycle pulse on the last beat of the port's burst.
- req_dout  out  DATA_W  read data, shared by all ports; qualify with req_valid.
- ddr_rd, ddr_wr  out  1  upstream command strobes.
- ddr_addr  out  ADDR_W  upstream address.
- ddr_burstLength  out  8  upstream beat count.
- ddr_mask  out  DATA_W/8  upstream byte enables.
- ddr_din  out  DATA_W  upstream write data.
- ddr_dout  in  DATA_W  upstream read data.
- ddr_waitReq  in  1  upstream stall.
- ddr_valid  in  1  upstream read-data strobe.

## Operation
- States: IDLE, READ, WRITE.
- IDLE:
  - The round-robin encoder picks the first port with rd|wr, searching from `ptr` upward and wrapping at NUM_REQ.
  - The winner's command fields drive ddr_* combinationally; its req_waitReq = ddr_waitReq. All other ports see waitReq=1.
  - A command is accepted when the strobe is high and ddr_waitReq=0.
  - On acceptance, latch `owner`, set `ptr` = owner+1 (mod NUM_REQ), and load `beats` = burstLength. A burstLength of 0 is loaded as 1.
  - Accepted read: go to READ.
  - Accepted write: if beats==1, pulse burstDone and stay in IDLE; else decrement and go to WRITE.
- READ:
  - ddr_rd=0; every req_waitReq=1.
  - req_valid[owner] = ddr_valid; req_dout = ddr_dout.
  - Each valid beat decrements `beats`. On the last beat, pulse burstDone[owner] and return to IDLE.
- WRITE:
  - Only `owner` is forwarded; req_waitReq[owner] = ddr_waitReq and all others are 1.
  - Each beat with wr & ~waitReq decrements `beats`. On the last beat, pulse burstDone and return to IDLE.
  - If the owner drops wr mid-burst, ddr_wr=0 and the burst does not advance.
- A port asserting both rd and wr is served as a read.
- ddr_valid outside READ is dropped: req_valid stays all-zero.

## Timing
- Zero-cycle grant in IDLE: a lone requester's command reaches ddr_* in the same cycle.
- Back-to-back bursts: after a burst's last beat, IDLE may accept the next command on the following cycle.
- Read data and valid pass through combinationally, so latency is 0 cycles from ddr_valid.
- During reset and on the first cycle after reset:
  - state=IDLE, ptr=0, owner=0, beats=0.
  - ddr_rd=ddr_wr=0, all req_waitReq=1, req_valid=0, burstDone=0.
- Reset mid-burst aborts the burst without a burstDone pulse. Late ddr_valid beats are discarded.
- beats counter is 8 bits, so burstLength 255 is the maximum.

## Structure
- Package `ddr_arbiter_pkg` holds:
  - the state enum (IDLE, READ, WRITE);
  - the localparam MAX_REQ=8;
  - a clog2-based index width function.
- Sub-module `rr_priority_encoder`: combinational round-robin encoder.
  - Inputs: request vector, `ptr`.
  - Outputs: grant index and `any`.

## Test plan
- Single port 1 reads burst 4 at 0x0000_1000 → ddr_rd=1 and ddr_addr=0x1000 on cycle 0. Four ddr_valid beats reach req_valid[1] only. burstDone[1] pulses on beat 4.
- Ports 0 and 2 both request with ptr=0 → port 0 is served first and port 2 next. A new port-0 request is then queued behind port 2.
- Port 0 writes burst 3 while ddr_waitReq is high for 2 cycles mid-burst → exactly 3 accepted beats, burstDone on the third, port 1 stalled throughout.
- burstLength=0 read → treated as 1 beat; burstDone on the first ddr_valid.
- reset_n low during READ after 2 of 8 beats → state IDLE, outputs at reset values, remaining ddr_valid beats produce no req_valid.
- Write burst 1 followed by an immediate read from another port → burstDone on the write's acceptance cycle, and the read is granted the next cycle.
